// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the integer register file's single write port.
//
// Takes results from two producers (ALU path and load path), arbitrates between
// them with a one-entry hold buffer, registers the chosen write, and counts
// retired writeback slots in a 64-bit counter.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   alu_valid/ready   ALU handshake; alu_rd/alu_result carry the result
//   ld_valid/ready    load handshake; ld_rd, ld_funct3, ld_addr_lo, ld_rdata
//                     carry the raw aligned word and how to extract from it
//   rf_we/rf_rd/rf_wd registered register-file write port
//   hold_busy         hold buffer occupied (a deferred load is pending)
//   instret           number of retired writeback slots, wraps at 2^64
module wb_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [RA_W-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [RA_W-1:0] ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_rdata,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_rd,
    output logic [XLEN-1:0] rf_wd,
    output logic            hold_busy,
    output logic [63:0]     instret
);

    logic            hold_valid;
    logic [RA_W-1:0] hold_rd;
    logic [XLEN-1:0] hold_data;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    logic alu_fire;
    logic ld_fire;

    // Readiness depends only on state so neither producer sees a
    // combinational path from its own valid.
    assign alu_ready = !hold_valid && !rst;
    assign ld_ready  = !hold_valid && !rst;
    assign hold_busy = hold_valid;

    assign alu_fire = alu_valid && alu_ready;
    assign ld_fire  = ld_valid && ld_ready;

    // Byte lane picked by the full offset; halfword lane only by bit 1.
    assign ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = '0;
        case (ld_funct3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010:  ld_data = ld_rdata;
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            // Undefined load types still retire, writing zero.
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            instret    <= '0;
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
        end else if (hold_valid) begin
            // Draining the hold takes the slot; inputs are stalled.
            rf_we      <= (hold_rd != '0);
            rf_rd      <= hold_rd;
            rf_wd      <= hold_data;
            instret    <= instret + 64'd1;
            hold_valid <= 1'b0;
        end else if (alu_fire) begin
            rf_we   <= (alu_rd != '0);
            rf_rd   <= alu_rd;
            rf_wd   <= alu_result;
            instret <= instret + 64'd1;
            // A simultaneous load is parked and written next cycle, so on an
            // rd collision the load value is the one left in the file.
            if (ld_fire) begin
                hold_valid <= 1'b1;
                hold_rd    <= ld_rd;
                hold_data  <= ld_data;
            end
        end else if (ld_fire) begin
            rf_we   <= (ld_rd != '0);
            rf_rd   <= ld_rd;
            rf_wd   <= ld_data;
            instret <= instret + 64'd1;
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a
// queue-based reference model of the writeback ordering.
module tb_wb_stage;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic            alu_ready;
    logic [RA_W-1:0] alu_rd;
    logic [XLEN-1:0] alu_result;
    logic            ld_valid;
    logic            ld_ready;
    logic [RA_W-1:0] ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic [XLEN-1:0] ld_rdata;
    logic            rf_we;
    logic [RA_W-1:0] rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic            hold_busy;
    logic [63:0]     instret;

    wb_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_rdata(ld_rdata),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .hold_busy(hold_busy), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] wd;
    } slot_t;

    // Reference model: every accepted result joins an ordered list of pending
    // writes (ALU before load); one pending write leaves per cycle.
    slot_t           pend[$];
    logic            m_we;
    logic [RA_W-1:0] m_rd;
    logic [XLEN-1:0] m_wd;
    logic [63:0]     m_instret;

    int tests = 0;
    int fails = 0;

    function automatic logic [XLEN-1:0] ref_load(input logic [2:0] f3, input int unsigned a,
                                                 input logic [XLEN-1:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (32'hFFFF_FF00 | b) : b;
            3'd1:    return (h >= 32768) ? (32'hFFFF_0000 | h) : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        alu_valid  = 1'b0;
        ld_valid   = 1'b0;
        alu_rd     = '0;
        alu_result = '0;
        ld_rd      = '0;
        ld_funct3  = '0;
        ld_addr_lo = '0;
        ld_rdata   = '0;
    endtask

    task automatic drive_alu(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] res);
        alu_valid  = 1'b1;
        alu_rd     = rd;
        alu_result = res;
    endtask

    task automatic drive_ld(input logic [RA_W-1:0] rd, input logic [2:0] f3,
                            input logic [1:0] a, input logic [XLEN-1:0] w);
        ld_valid   = 1'b1;
        ld_rd      = rd;
        ld_funct3  = f3;
        ld_addr_lo = a;
        ld_rdata   = w;
    endtask

    // One clock with the currently driven inputs; checks readies before the
    // edge and all registered outputs just after it.
    task automatic cycle();
        logic  exp_rdy;
        logic  af;
        logic  lf;
        slot_t s_alu;
        slot_t s_ld;
        slot_t s;
        #1;
        exp_rdy = (pend.size() == 0) && !rst;
        check("alu_ready", alu_ready, exp_rdy);
        check("ld_ready", ld_ready, exp_rdy);
        af = alu_valid && exp_rdy;
        lf = ld_valid && exp_rdy;
        s_alu.rd = alu_rd;
        s_alu.wd = alu_result;
        s_ld.rd  = ld_rd;
        s_ld.wd  = ref_load(ld_funct3, int'(ld_addr_lo), ld_rdata);
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
            m_we = 1'b0;
            m_rd = '0;
            m_wd = '0;
            m_instret = '0;
        end else begin
            if (af) pend.push_back(s_alu);
            if (lf) pend.push_back(s_ld);
            if (pend.size() != 0) begin
                s = pend.pop_front();
                m_we = (s.rd != 0);
                m_rd = s.rd;
                m_wd = s.wd;
                m_instret = m_instret + 64'd1;
            end else begin
                m_we = 1'b0;
            end
        end
        check("rf_we", rf_we, m_we);
        check("rf_rd", rf_rd, m_rd);
        check("rf_wd", rf_wd, m_wd);
        check("hold_busy", hold_busy, pend.size() != 0);
        check("instret", instret, m_instret);
    endtask

    logic [2:0]      t2_f3[5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]      t2_a[5]   = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [XLEN-1:0] t2_exp[5] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081,
                                   32'h0000_F2F3, 32'h8081_F2F3};

    initial begin
        logic [63:0] base;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
        m_instret = '0;
        rst = 1'b1;
        set_idle();

        // Reset state
        cycle();
        cycle();
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_instret", instret, 64'd0);
        check("reset_ready", alu_ready, 1'b0);
        rst = 1'b0;

        // 1: single ALU write
        drive_alu(5'd5, 32'hDEAD_BEEF);
        cycle();
        check("t1_we", rf_we, 1'b1);
        check("t1_rd", rf_rd, 5'd5);
        check("t1_wd", rf_wd, 32'hDEAD_BEEF);
        check("t1_instret", instret, 64'd1);

        // 2: load extraction cases
        for (int i = 0; i < 5; i++) begin
            set_idle();
            drive_ld(5'd7, t2_f3[i], t2_a[i], 32'h8081_F2F3);
            cycle();
            check("t2_wd", rf_wd, t2_exp[i]);
            check("t2_we", rf_we, 1'b1);
        end

        // 3: same-cycle collision on x3
        set_idle();
        base = instret;
        drive_alu(5'd3, 32'h11);
        drive_ld(5'd3, 3'b010, 2'd0, 32'h22);
        cycle();
        check("t3_first_wd", rf_wd, 32'h11);
        check("t3_first_rd", rf_rd, 5'd3);
        check("t3_busy", hold_busy, 1'b1);
        check("t3_alu_ready", alu_ready, 1'b0);
        check("t3_ld_ready", ld_ready, 1'b0);
        cycle();
        check("t3_second_wd", rf_wd, 32'h22);
        check("t3_second_we", rf_we, 1'b1);
        check("t3_busy_clr", hold_busy, 1'b0);
        check("t3_instret", instret - base, 64'd2);
        set_idle();
        cycle();
        check("t3_idle_we", rf_we, 1'b0);

        // 4: rd=0 retires but does not write
        base = instret;
        drive_alu(5'd0, 32'h55);
        cycle();
        check("t4_we", rf_we, 1'b0);
        check("t4_instret", instret - base, 64'd1);

        // 5: illegal funct3 writes zero
        set_idle();
        drive_ld(5'd9, 3'b011, 2'd1, 32'hFFFF_FFFF);
        cycle();
        check("t5_wd", rf_wd, 32'h0);
        check("t5_we", rf_we, 1'b1);

        // 6: reset while a load is held
        set_idle();
        drive_alu(5'd4, 32'hA5);
        drive_ld(5'd6, 3'b010, 2'd0, 32'h5A);
        cycle();
        check("t6_busy", hold_busy, 1'b1);
        set_idle();
        rst = 1'b1;
        cycle();
        check("t6_busy_clr", hold_busy, 1'b0);
        check("t6_we", rf_we, 1'b0);
        check("t6_instret", instret, 64'd0);
        rst = 1'b0;
        cycle();
        check("t6_no_held_write", rf_we, 1'b0);
        cycle();
        check("t6_no_held_write2", rf_we, 1'b0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1)
                drive_alu(5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 1) == 1)
                drive_ld(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                         2'($urandom_range(0, 3)), $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
